serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_sub_if.sv | 30 +++
 rtl/serial_sub_fa.sv | 12 +
 rtl/serial_sub.sv | 101 ++++++++++
 tb/tb_serial_sub.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and default width for serial_sub
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - operand/result handshake bundle for serial_sub
// Operand side:  in_valid, in_ready, a (minuend), b (subtrahend)
// Result side:   out_valid, out_ready, diff, borrow, ovf
// master: the producer/consumer driving operands and taking results
// slave:  the subtractor
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
endinterface

// File: rtl/serial_sub_fa.sv
// rtl/serial_sub_fa.sv - one-bit full adder cell used as the serial arithmetic core
// Ports: a, b, cin (inputs); sum, cout (outputs)
module serial_sub_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor computing a - b LSB-first as a + ~b + 1
// Ports: clk, rst_n (async active-low), bus (serial_sub_if.slave: operand and
// result valid/ready handshakes, diff, borrow, ovf)
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_shifted;
    logic             carry;
    logic [CW-1:0]    counter;
    logic             a_msb;
    logic             b_msb;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_bit = (state == RUN) && (counter == CW'(WIDTH - 1));

    // Inverted subtrahend bit plus carry seeded to 1 turns the adder into a - b.
    serial_sub_fa u_fa (
        .a    (sa[0]),
        .b    (~sb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Each new sum bit enters at the MSB so after WIDTH shifts bit 0 lands at result[0].
    generate
        if (WIDTH == 1) begin : g_shift_one
            assign result_shifted = fa_sum;
        end else begin : g_shift_many
            assign result_shifted = {fa_sum, result[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_bit)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            result  <= '0;
            carry   <= 1'b0;
            counter <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
        end else if (accept) begin
            sa      <= bus.a;
            sb      <= bus.b;
            carry   <= 1'b1;
            counter <= '0;
            a_msb   <= bus.a[WIDTH-1];
            b_msb   <= bus.b[WIDTH-1];
        end else if (state == RUN) begin
            sa      <= sa >> 1;
            sb      <= sb >> 1;
            result  <= result_shifted;
            carry   <= fa_cout;
            counter <= counter + CW'(1);
        end
    end

    // Flags are qualified by DONE so they read 0 outside a presented result.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = result;
    assign bus.borrow    = (state == DONE) & ~carry;
    assign bus.ovf       = (state == DONE) & (a_msb ^ b_msb) & (result[WIDTH-1] ^ a_msb);

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub at WIDTH=8 and WIDTH=1
module tb_serial_sub;
    import serial_sub_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8)) if8 ();
    serial_sub_if #(.WIDTH(1)) if1 ();

    serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    assign if8.in_valid  = in_valid & ~sel;
    assign if8.out_ready = out_ready & ~sel;
    assign if8.a         = a;
    assign if8.b         = b;
    assign if1.in_valid  = in_valid & sel;
    assign if1.out_ready = out_ready & sel;
    assign if1.a         = a[0];
    assign if1.b         = b[0];

    logic       in_ready_m;
    logic       out_valid_m;
    logic [7:0] diff_m;
    logic       borrow_m;
    logic       ovf_m;

    assign in_ready_m  = sel ? if1.in_ready  : if8.in_ready;
    assign out_valid_m = sel ? if1.out_valid : if8.out_valid;
    assign diff_m      = sel ? {7'b0, if1.diff} : if8.diff;
    assign borrow_m    = sel ? if1.borrow    : if8.borrow;
    assign ovf_m       = sel ? if1.ovf       : if8.ovf;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the result handshake.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          output logic [7:0] d, output logic bo, output logic ov,
                          output int lat);
        int n = 0;
        while (!in_ready_m && n < 200) begin
            @(negedge clk);
            n++;
        end
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_m && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        d  = diff_m;
        bo = borrow_m;
        ov = ovf_m;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic void model(input int w, input logic [7:0] op_a, input logic [7:0] op_b,
                                  output logic [7:0] d, output logic bo, output logic ov);
        int mask = (1 << w) - 1;
        int half = 1 << (w - 1);
        int ua = int'(op_a) & mask;
        int ub = int'(op_b) & mask;
        int sa_v = (ua >= half) ? ua - (1 << w) : ua;
        int sb_v = (ub >= half) ? ub - (1 << w) : ub;
        int sd = sa_v - sb_v;
        d  = 8'((ua - ub) & mask);
        bo = (ua < ub);
        ov = (sd < -half) || (sd > half - 1);
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] d;
        logic [7:0] ed;
        logic       bo;
        logic       ov;
        logic       ebo;
        logic       eov;
        logic       stable;
        int         lat;
        int         n;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b0};

        sel = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready_m, 1);
        check("reset_out_valid", out_valid_m, 0);
        check("reset_diff", diff_m, 0);
        check("reset_borrow", borrow_m, 0);
        check("reset_ovf", ovf_m, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, d, bo, ov, lat);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_diff", i), d, vecs[i].d);
            check($sformatf("vec%0d_borrow", i), bo, vecs[i].bo);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
            check($sformatf("vec%0d_ready_after", i), in_ready_m, 1);
        end

        // Back-pressure: DONE must hold with new operands waiting.
        a = 8'h05;
        b = 8'h03;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_m && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", n, 8);
        in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
            if (diff_m !== 8'h02 || out_valid_m !== 1'b1 || in_ready_m !== 1'b0 ||
                borrow_m !== 1'b0 || ovf_m !== 1'b0)
                stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1);
        a = 8'h09;
        b = 8'h04;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ready_after_release", in_ready_m, 1);
        check("bp_valid_after_release", out_valid_m, 0);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_m && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_latency", n, 8);
        check("bp_next_diff", diff_m, 8'h05);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN discards the partial result.
        a = 8'h33;
        b = 8'h11;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid_m, 0);
        check("rst_mid_diff", diff_m, 0);
        check("rst_mid_borrow", borrow_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h10, 8'h01, d, bo, ov, lat);
        check("post_rst_latency", lat, 8);
        check("post_rst_diff", d, 8'h0F);
        check("post_rst_borrow", bo, 0);
        check("post_rst_ovf", ov, 0);

        // Random scoreboard at both widths.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                logic [7:0] ra;
                logic [7:0] rb;
                ra = 8'($urandom);
                rb = 8'($urandom);
                run_op(ra, rb, d, bo, ov, lat);
                model(s == 0 ? 8 : 1, ra, rb, ed, ebo, eov);
                check($sformatf("rand_w%0d_latency", s == 0 ? 8 : 1), lat, s == 0 ? 8 : 1);
                check($sformatf("rand_diff a=%0h b=%0h", ra, rb), d, ed);
                check($sformatf("rand_borrow a=%0h b=%0h", ra, rb), bo, ebo);
                check($sformatf("rand_ovf a=%0h b=%0h", ra, rb), ov, eov);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
